fifo_pop_stream: RTL and testbench

//  Read-side drain engine for the 8-bit FIFO memory. Issues single-cycle pops against the FIFO's

---
 rtl/fifo_pop_stream.sv | 211 +++++++++++++++++++++
 tb/tb_fifo_pop_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stream.sv
// ---------------------------------------------------------------------------
// fifo_pop_stream
// Read-side drain engine for the byte FIFO. Issues single-cycle pops on the
// FIFO read port and absorbs the FIFO's one-cycle registered read latency in
// a 2-entry skid buffer. The bytes are presented as a valid/ready stream,
// framed into bursts of BURST_LEN beats with m_last on the final beat.
//
// Ports
//   clk, rst     : single clock; synchronous active-high reset
//   enable       : 1 allows new pops; 0 stops new pops, buffered data drains
//   flush        : 1-cycle pulse; discards the buffer, empties the FIFO and
//                  restarts burst framing
//   fifo_empty   : FIFO empty flag
//   fifo_rdata   : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd      : pop strobe to the FIFO (combinational)
//   m_valid      : stream data valid
//   m_data       : stream data (head of the skid buffer)
//   m_last       : final beat of the current burst
//   m_ready      : downstream accept
//   busy         : engine active, data buffered or a pop in flight
//
// Build option FIFO_POP_STATS_EN adds:
//   pop_count    : saturating count of pops issued outside FLUSH
//   err_pop      : sticky error; pop while empty or capture into full buffer
// ---------------------------------------------------------------------------
module fifo_pop_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
`ifdef FIFO_POP_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_POP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  err_pop
`endif
);

  localparam int unsigned BEAT_W    = 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  logic                  pop_out;
  logic                  drop;
  logic                  capture;
  logic                  can_pop;
  logic [2:0]            credit_used;
  logic [1:0]            wr_idx;

  // Stream-side decode of the registered buffer state
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = slot0_q;
  assign m_last  = m_valid & (beat_q == LAST_BEAT);
  assign busy    = (state_q != ST_IDLE) | m_valid | inflight_q;

  assign pop_out = m_valid & m_ready;
  // Anything captured while flushing (or on the flush pulse itself) is discarded
  assign drop    = flush | (state_q == ST_FLUSH);
  assign capture = inflight_q & ~drop;

  // Credit: slots held plus pops in flight, less the beat leaving this cycle
  assign credit_used = 3'(occ_q) + 3'(inflight_q);
  assign can_pop     = credit_used < (3'd2 + 3'(pop_out));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over enable except while already flushing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (!enable && (occ_q == 2'd0) && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty && !inflight_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: pop strobe
  always_comb begin
    fifo_rd = 1'b0;
    case (state_q)
      ST_RUN:   fifo_rd = enable & ~fifo_empty & can_pop;
      ST_FLUSH: fifo_rd = ~fifo_empty;
      default:  fifo_rd = 1'b0;
    endcase
  end

  // Skid buffer: slot0 is the head; a pop shifts slot1 forward and the
  // captured byte lands in the first free slot after that shift
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    wr_idx  = occ_q - 2'(pop_out);
    if (drop) begin
      occ_d = 2'd0;
    end else begin
      if (pop_out) begin
        slot0_d = slot1_q;
      end
      if (capture) begin
        if (wr_idx == 2'd0) begin
          slot0_d = fifo_rdata;
        end else if (wr_idx == 2'd1) begin
          slot1_d = fifo_rdata;
        end
      end
      occ_d = occ_q + 2'(capture & (wr_idx != 2'd2)) - 2'(pop_out);
    end
  end

  // Burst framing counter
  always_comb begin
    beat_d = beat_q;
    if (drop) begin
      beat_d = '0;
    end else if (pop_out) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      beat_q     <= '0;
    end else begin
      inflight_q <= fifo_rd;
      occ_q      <= occ_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      beat_q     <= beat_d;
    end
  end

`ifdef FIFO_POP_STATS_EN
  logic [CNT_WIDTH-1:0] pop_count_q;
  logic                 err_pop_q;

  // Pop statistics and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count_q <= '0;
      err_pop_q   <= 1'b0;
    end else begin
      if (fifo_rd && (state_q != ST_FLUSH) && (pop_count_q != '1)) begin
        pop_count_q <= pop_count_q + CNT_WIDTH'(1);
      end
      if ((fifo_rd && fifo_empty) || (inflight_q && (occ_q == 2'd2))) begin
        err_pop_q <= 1'b1;
      end
    end
  end

  assign pop_count = pop_count_q;
  assign err_pop   = err_pop_q;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a behavioural FIFO and a
// scoreboard of expected stream beats (data plus m_last).
module tb_fifo_pop_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
`ifdef FIFO_POP_STATS_EN
  logic [15:0]   pop_count;
  logic          err_pop;
`endif

  fifo_pop_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy)
`ifdef FIFO_POP_STATS_EN
    ,
    .pop_count  (pop_count),
    .err_pop    (err_pop)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW:0]   exp_q[$];
  int            exp_beat = 0;
  bit            model_empty = 1'b0;
  int            errors = 0;
  int            checks = 0;
  int            cyc_n = 0;
  int            pops = 0;
  int            xfers = 0;
  int            first_rd = -1;
  int            first_x = -1;
  int            last_x = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_q.push_back({(exp_beat == BL - 1), d});
    exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
  endtask

  task automatic push_fifo(input logic [DW-1:0] d);
    fq.push_back(d);
    if (model_empty) fifo_empty = (fq.size() == 0);
  endtask

  task automatic clr_counters();
    pops = 0; xfers = 0; first_rd = -1; first_x = -1; last_x = -1;
  endtask

  // One clock: sample at negedge, then model the FIFO's registered read
  task automatic cyc();
    logic          rd_s;
    logic [DW:0]   e;
    @(negedge clk);
    rd_s = fifo_rd;
    check("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
    if (rd_s && first_rd < 0) first_rd = cyc_n;
    if (!rst && m_valid && m_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e[DW-1:0]));
        check("m_last", 32'(m_last), 32'(e[DW]));
      end
      xfers++;
      if (first_x < 0) first_x = cyc_n;
      last_x = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_s) begin
      pops++;
      if (fq.size() != 0) fifo_rdata = fq.pop_front();
    end
    if (model_empty) fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    // Reset with a non-empty FIFO and enable high
    rst = 1'b1; enable = 1'b1; fifo_empty = 1'b0; model_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    rst = 1'b0; enable = 1'b0; model_empty = 1'b1; fifo_empty = 1'b1;
    repeat (2) cyc();
    check("idle_busy", 32'(busy), 32'd0);

    // Full-rate stream of 8 bytes, two bursts
    clr_counters();
    for (int i = 0; i < 8; i++) begin
      push_fifo(8'(8'h10 + i));
      push_exp(8'(8'h10 + i));
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30 && xfers < 8; i++) cyc();
    check("s_xfers", 32'(xfers), 32'd8);
    check("s_latency", 32'(first_x - first_rd), 32'd2);
    check("s_back_to_back", 32'(last_x - first_x), 32'd7);
    check("s_pops", 32'(pops), 32'd8);
    check("s_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) cyc();
    check("s_rd_low_empty", 32'(fifo_rd), 32'd0);
    check("s_drained", 32'(m_valid), 32'd0);

    // Backpressure: only two pops fit while the sink stalls
    clr_counters();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_fifo(8'(8'h20 + i));
      push_exp(8'(8'h20 + i));
    end
    repeat (10) cyc();
    check("bp_pops", 32'(pops), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_head", 32'(m_data), 32'h20);
    m_ready = 1'b1;
    for (int i = 0; i < 30 && xfers < 6; i++) cyc();
    check("bp_xfers", 32'(xfers), 32'd6);
    check("bp_pops_total", 32'(pops), 32'd6);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Enable drop after the third pop
    clr_counters();
    for (int i = 0; i < 6; i++) push_fifo(8'(8'h30 + i));
    for (int i = 0; i < 3; i++) push_exp(8'(8'h30 + i));
    for (int i = 0; i < 20 && pops < 3; i++) cyc();
    enable = 1'b0;
    repeat (10) cyc();
    check("en_pops", 32'(pops), 32'd3);
    check("en_xfers", 32'(xfers), 32'd3);
    check("en_busy", 32'(busy), 32'd0);
    check("en_rd", 32'(fifo_rd), 32'd0);
    check("en_left_in_fifo", 32'(fq.size()), 32'd3);

    // Flush after two transfers out of ten queued bytes
    clr_counters();
    push_exp(8'h33);
    push_exp(8'h34);
    for (int i = 0; i < 7; i++) push_fifo(8'(8'h40 + i));
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20 && xfers < 2; i++) cyc();
    flush = 1'b1; m_ready = 1'b0; enable = 1'b0;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    check("fl_valid_off", 32'(m_valid), 32'd0);
    check("fl_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && busy; i++) cyc();
    check("fl_idle", 32'(busy), 32'd0);
    check("fl_fifo_drained", 32'(fq.size()), 32'd0);
    check("fl_xfers", 32'(xfers), 32'd2);
    clr_counters();
    for (int i = 0; i < 4; i++) begin
      push_fifo(8'(8'h50 + i));
      push_exp(8'(8'h50 + i));
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20 && xfers < 4; i++) cyc();
    check("fl_next_xfers", 32'(xfers), 32'd4);
    check("fl_next_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_POP_STATS_EN
    // Pop statistics and sticky error flag
    m_ready = 1'b0; enable = 1'b0; rst = 1'b1;
    exp_q.delete(); exp_beat = 0;
    cyc();
    rst = 1'b0;
    check("st_cnt_rst", 32'(pop_count), 32'd0);
    check("st_err_rst", 32'(err_pop), 32'd0);
    clr_counters();
    for (int i = 0; i < 8; i++) begin
      push_fifo(8'(8'h60 + i));
      push_exp(8'(8'h60 + i));
    end
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30 && xfers < 8; i++) cyc();
    repeat (2) cyc();
    check("st_cnt8", 32'(pop_count), 32'd8);
    check("st_err0", 32'(err_pop), 32'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_fifo(8'(8'h70 + i));
    repeat (6) cyc();
    check("st_buf_full", 32'(m_valid), 32'd1);
    model_empty = 1'b0; fifo_empty = 1'b1;
    force dut.inflight_q = 1'b1;
    cyc();
    release dut.inflight_q;
    repeat (3) cyc();
    check("st_err_set", 32'(err_pop), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("st_err_clr", 32'(err_pop), 32'd0);
    check("st_cnt_clr", 32'(pop_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
